// File: rtl/bpsk_modulator_if.sv
// rtl/bpsk_modulator_if.sv - coded-bit input and I/Q sample output bundle for bpsk_modulator
interface bpsk_modulator_if #(
  parameter int DATA_WIDTH = 13
);
  logic                  bit_i;
  logic                  valid_i;
  logic [31:0]           cycles_per_bit;
  logic [DATA_WIDTH-1:0] i_data_o;
  logic [DATA_WIDTH-1:0] q_data_o;
  logic                  valid_o;

  // Upstream side: channel coder drives bits, DAC side consumes samples
  modport master (
    output bit_i, valid_i, cycles_per_bit,
    input  i_data_o, q_data_o, valid_o
  );

  // Modulator side
  modport slave (
    input  bit_i, valid_i, cycles_per_bit,
    output i_data_o, q_data_o, valid_o
  );
endinterface

// File: rtl/bpsk_modulator.sv
// rtl/bpsk_modulator.sv - serial bit to BPSK I sample mapper with programmable symbol length; BPSK_NRZM_EN enables NRZ-M differential encoding
module bpsk_modulator #(
  parameter int DATA_WIDTH = 13,
  parameter int AMPLITUDE  = 4095
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bpsk_modulator_if.slave    bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [DATA_WIDTH-1:0] POS_SAMPLE = DATA_WIDTH'(AMPLITUDE);
  localparam logic [DATA_WIDTH-1:0] NEG_SAMPLE = DATA_WIDTH'(-AMPLITUDE);

  logic [0:0]            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           limit_q, limit_d;
  logic [DATA_WIDTH-1:0] i_q, i_d;
  logic                  valid_q, valid_d;
  logic                  start_sym;
  logic                  stop_sym;
  logic [DATA_WIDTH-1:0] sym_sample;

`ifdef BPSK_NRZM_EN
  logic phase_q, phase_d;
  logic next_phase;
`endif

  // Decide whether this clock starts a new symbol, ends the stream, or holds
  always_comb begin
    start_sym = 1'b0;
    stop_sym  = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) start_sym = 1'b1;
        else             stop_sym  = 1'b1;
      end
      default: begin
        // limit_q was captured at symbol start, so mid-symbol cpb changes wait
        if (cnt_q == limit_q) begin
          if (bus.valid_i) start_sym = 1'b1;
          else             stop_sym  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  // Map the incoming bit to a sample (differentially when NRZ-M is enabled)
  always_comb begin
`ifdef BPSK_NRZM_EN
    next_phase = bus.bit_i ? ~phase_q : phase_q;
    sym_sample = next_phase ? POS_SAMPLE : NEG_SAMPLE;
`else
    sym_sample = bus.bit_i ? POS_SAMPLE : NEG_SAMPLE;
`endif
  end

  // Next-state values for the symbol registers
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    i_d     = i_q;
    valid_d = valid_q;
`ifdef BPSK_NRZM_EN
    phase_d = phase_q;
`endif
    if (start_sym) begin
      state_d = RUN;
      limit_d = (bus.cycles_per_bit == 32'd0) ? 32'd0 : bus.cycles_per_bit - 32'd1;
      i_d     = sym_sample;
      valid_d = 1'b1;
`ifdef BPSK_NRZM_EN
      phase_d = next_phase;
`endif
    end else if (stop_sym) begin
      state_d = IDLE;
      limit_d = 32'd0;
      i_d     = '0;
      valid_d = 1'b0;
`ifdef BPSK_NRZM_EN
      phase_d = 1'b1;
`endif
    end
  end

  // Registers; counter is cleared whenever a symbol starts or the stream ends
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      limit_q <= 32'd0;
      i_q     <= '0;
      valid_q <= 1'b0;
`ifdef BPSK_NRZM_EN
      phase_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= (start_sym || stop_sym) ? 32'd0 : cnt_d;
      limit_q <= limit_d;
      i_q     <= i_d;
      valid_q <= valid_d;
`ifdef BPSK_NRZM_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign bus.i_data_o = i_q;
  assign bus.q_data_o = '0;
  assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// tb/tb_bpsk_modulator.sv - scoreboard bench for bpsk_modulator
module tb_bpsk_modulator;
  localparam int DW = 13;
  localparam logic [DW-1:0] POS = 13'h0FFF;
  localparam logic [DW-1:0] NEG = 13'h1001;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  bpsk_modulator_if #(.DATA_WIDTH(DW)) bus ();

  bpsk_modulator #(.DATA_WIDTH(DW), .AMPLITUDE(4095)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] i;
    logic          v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tb_phase = 1'b1;

  task automatic push(input logic [DW-1:0] i, input logic v);
    exp_t e;
    e.i = i;
    e.v = v;
    sb.push_back(e);
  endtask

  // Clock once, then check the outputs of that edge against the oldest expectation
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty got size %0d expected >0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (bus.i_data_o === e.i) else begin
        n_fail++;
        $error("FAIL %s i_data_o got %h expected %h", tag, bus.i_data_o, e.i);
      end
      n_tests++;
      assert (bus.q_data_o === '0) else begin
        n_fail++;
        $error("FAIL %s q_data_o got %h expected 0", tag, bus.q_data_o);
      end
      n_tests++;
      assert (bus.valid_o === e.v) else begin
        n_fail++;
        $error("FAIL %s valid_o got %b expected %b", tag, bus.valid_o, e.v);
      end
    end
  endtask

  // One symbol: bit held for max(cpb,1) clocks; valid_i drops after 'drop' clocks
  task automatic sym(input logic b, input int cpb, input int drop, input string tag);
    int k;
    logic [DW-1:0] exp_i;
    k = (cpb == 0) ? 1 : cpb;
`ifdef BPSK_NRZM_EN
    if (b) tb_phase = ~tb_phase;
    exp_i = tb_phase ? POS : NEG;
`else
    exp_i = b ? POS : NEG;
`endif
    for (int c = 0; c < k; c++) begin
      bus.bit_i          = (c == 0) ? b : ~b;
      bus.valid_i        = (c < drop) ? 1'b1 : 1'b0;
      bus.cycles_per_bit = (c == 0) ? cpb : cpb + 3;
      push(exp_i, 1'b1);
      tick(tag);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      bus.valid_i = 1'b0;
      bus.bit_i   = c[0];
      tb_phase    = 1'b1;
      push('0, 1'b0);
      tick(tag);
    end
  endtask

  logic [13:0] stream;

  initial begin
    stream             = 14'b10001111101001;
    rst_i              = 1'b1;
    bus.bit_i          = 1'b1;
    bus.valid_i        = 1'b1;
    bus.cycles_per_bit = 32'd1;

    push('0, 1'b0);
    tick("reset0");
    push('0, 1'b0);
    tick("reset1");
    rst_i = 1'b0;
    tb_phase = 1'b1;
    idle(2, "idle");

    for (int b = 13; b >= 0; b--) sym(stream[b], 1, 1, "cpb1");
    idle(2, "cpb1_end");

    for (int b = 13; b >= 0; b--) sym(stream[b], 6, 6, "cpb6");
    idle(2, "cpb6_end");

    for (int b = 13; b >= 0; b--) sym(stream[b], 0, 1, "cpb0");
    idle(2, "cpb0_end");

    sym(1'b0, 4, 4, "cpb4_first");
    sym(1'b1, 4, 2, "cpb4_drop");
    idle(3, "cpb4_end");

    sym(1'b1, 3, 3, "cpb_change3");
    sym(1'b0, 2, 2, "cpb_change2");
    sym(1'b1, 5, 5, "cpb_change5");
    idle(1, "cpb_change_end");

    bus.bit_i          = 1'b0;
    bus.valid_i        = 1'b1;
    bus.cycles_per_bit = 32'd6;
`ifdef BPSK_NRZM_EN
    push(POS, 1'b1);
`else
    push(NEG, 1'b1);
`endif
    tick("midrst_start");
    bus.bit_i = 1'b1;
`ifdef BPSK_NRZM_EN
    push(POS, 1'b1);
`else
    push(NEG, 1'b1);
`endif
    tick("midrst_hold");
    rst_i = 1'b1;
    push('0, 1'b0);
    tick("midrst_reset");
    rst_i = 1'b0;
    tb_phase = 1'b1;
    idle(2, "midrst_idle");

    sym(1'b1, 1, 1, "nrzm0");
    sym(1'b1, 1, 1, "nrzm1");
    sym(1'b0, 1, 1, "nrzm2");
    sym(1'b1, 1, 1, "nrzm3");
    idle(2, "nrzm_end");

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain leftover got %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
